// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS control unit: FSM state encodings,
// opcode/funct values, ALU operation classes and datapath mux encodings.
// No ports (package).
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    // Controller states; the numeric codes are visible on the State debug port.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // ALU operation class handed from the FSM to the ALU decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALUControl encodings
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // PCSrc encodings
    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for states whose exit to FETCH retires an instruction
    // (MEMWR is qualified with MemReady by the caller).
    function automatic logic f_retires(input state_t s);
        logic r;
        case (s)
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: r = 1'b1;
            default:                                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// -----------------------------------------------------------------------------
// mc_aludec
// Combinational ALU decoder. Maps the FSM's ALU operation class and the
// instruction funct field onto the 3-bit ALUControl code.
// Ports:
//   i_aluop           ALU operation class (add / sub / use funct)
//   i_funct           instr[5:0]
//   o_alu_control     ALU operation select
//   o_illegal_funct   funct not supported (meaningful only for ALUOP_FUNCT)
// -----------------------------------------------------------------------------
module mc_aludec
    import mc_ctrl_pkg::*;
(
    input  aluop_t      i_aluop,
    input  logic [5:0]  i_funct,
    output logic [2:0]  o_alu_control,
    output logic        o_illegal_funct
);

    // Decode ALU operation; unsupported funct falls back to add and flags it.
    always_comb begin
        o_alu_control   = ALU_ADD;
        o_illegal_funct = 1'b0;
        case (i_aluop)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alu_control = ALU_ADD;
                    FN_SUB:  o_alu_control = ALU_SUB;
                    FN_AND:  o_alu_control = ALU_AND;
                    FN_OR:   o_alu_control = ALU_OR;
                    FN_SLT:  o_alu_control = ALU_SLT;
                    default: begin
                        o_alu_control   = ALU_ADD;
                        o_illegal_funct = 1'b1;
                    end
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
// Multicycle MIPS control FSM. Sequences the shared ALU, register file and
// unified memory through fetch/decode/execute/memory/writeback, one state per
// clock, with a MemReady handshake for variable-latency memory.
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   Op, Funct, Zero     instruction fields and ALU zero flag
//   MemReady            memory completed the current access this cycle
//   MemRead, MemWrite, IorD, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
//   ALUControl, RegDst, MemtoReg, RegWrite   datapath controls (Moore)
//   Illegal             one-cycle pulse on unsupported opcode/funct
//   State               current state code (debug)
//   InstrCount          retired instruction count (wraps)
// -----------------------------------------------------------------------------
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCEn,
    output logic [1:0]  PCSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        Illegal,
    output logic [3:0]  State,
    output logic [31:0] InstrCount
);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_instr_count;

    aluop_t      w_alu_op;
    logic        w_illegal_funct;
    logic        w_retire;

    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_ir_write;
    logic        w_pc_write;
    logic        w_branch;
    logic        w_reg_write;
    logic        w_illegal;

    mc_aludec u_aludec (
        .i_aluop         (w_alu_op),
        .i_funct         (Funct),
        .o_alu_control   (ALUControl),
        .o_illegal_funct (w_illegal_funct)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Retired-instruction counter; illegal exits never reach a retiring state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_instr_count <= 32'd0;
        end else if (w_retire) begin
            r_instr_count <= r_instr_count + 32'd1;
        end else begin
            r_instr_count <= r_instr_count;
        end
    end

    // Retire strobe: the cycle that transitions back to FETCH after completion.
    always_comb begin
        w_retire = 1'b0;
        if (r_state == S_MEMWR) begin
            w_retire = MemReady;
        end else begin
            w_retire = f_retires(r_state);
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTE;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JUMP;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next_state = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next_state = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next_state = S_FETCH;
            S_MEMWR:   w_next_state = MemReady ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next_state = w_illegal_funct ? S_FETCH : S_ALUWB;
            S_ALUWB:   w_next_state = S_FETCH;
            S_BRANCH:  w_next_state = S_FETCH;
            S_ADDIEX:  w_next_state = S_ADDIWB;
            S_ADDIWB:  w_next_state = S_FETCH;
            S_JUMP:    w_next_state = S_FETCH;
            default:   w_next_state = S_FETCH;
        endcase
    end

    // ALU operation class; kept apart from output decode so the decoder's
    // illegal flag feeds back without forming a combinational block loop.
    always_comb begin
        w_alu_op = ALUOP_ADD;
        case (r_state)
            S_EXECUTE: w_alu_op = ALUOP_FUNCT;
            S_BRANCH:  w_alu_op = ALUOP_SUB;
            default:   w_alu_op = ALUOP_ADD;
        endcase
    end

    // Moore output decode (raw, before reset gating).
    always_comb begin
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        IorD        = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        PCSrc       = PCSRC_ALURES;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                // PC+4 and IR load only complete with the memory handshake.
                w_ir_write = MemReady;
                w_pc_write = MemReady;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMMSH2;
                case (Op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: w_illegal = 1'b0;
                    default:                                       w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                IorD       = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg    = 1'b1;
                w_reg_write = 1'b1;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                IorD        = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA   = 1'b1;
                w_illegal = w_illegal_funct;
            end
            S_ALUWB: begin
                RegDst      = 1'b1;
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                PCSrc    = PCSRC_ALUOUT;
                w_branch = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
            end
            S_JUMP: begin
                PCSrc      = PCSRC_JUMP;
                w_pc_write = 1'b1;
            end
            default: begin
                w_mem_read = 1'b0;
            end
        endcase
    end

    // Side-effecting strobes are held low while reset is asserted.
    assign MemRead    = w_mem_read  & ~RST;
    assign MemWrite   = w_mem_write & ~RST;
    assign IRWrite    = w_ir_write  & ~RST;
    assign RegWrite   = w_reg_write & ~RST;
    assign Illegal    = w_illegal   & ~RST;
    assign PCEn       = (w_pc_write | (w_branch & Zero)) & ~RST;
    assign State      = r_state;
    assign InstrCount = r_instr_count;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through its
// state sequence and compares controls against hand-derived values.
module tb_mc_controller;
    logic        CLK = 1'b0;
    logic        RST;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        Zero;
    logic        MemReady;
    logic        MemRead, MemWrite, IorD, IRWrite, PCEn;
    logic [1:0]  PCSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic        RegDst, MemtoReg, RegWrite, Illegal;
    logic [3:0]  State;
    logic [31:0] InstrCount;

    int checks   = 0;
    int failures = 0;

    mc_controller dut (
        .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .MemRead(MemRead), .MemWrite(MemWrite),
        .IorD(IorD), .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .Illegal(Illegal), .State(State), .InstrCount(InstrCount)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled mid-low-phase.
    task automatic next_cycle();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; Op = 6'b000000; Funct = 6'b000000; Zero = 1'b0; MemReady = 1'b1;
        next_cycle();
        // Reset state with strobes forced low
        check("rst_state", {28'd0, State}, 32'd0);
        check("rst_count", InstrCount, 32'd0);
        check("rst_memread", {31'd0, MemRead}, 32'd0);
        check("rst_irwrite", {31'd0, IRWrite}, 32'd0);
        check("rst_pcen", {31'd0, PCEn}, 32'd0);

        // Release reset with a fetch wait
        RST = 1'b0; MemReady = 1'b0; #1;
        check("fetch_memread", {31'd0, MemRead}, 32'd1);
        check("fetch_wait_ir", {31'd0, IRWrite}, 32'd0);
        check("fetch_wait_pcen", {31'd0, PCEn}, 32'd0);
        next_cycle();
        check("fetch_hold", {28'd0, State}, 32'd0);

        // lw, zero wait: 0,1,2,3,4,0
        MemReady = 1'b1; Op = 6'b100011; #1;
        check("lw_ir", {31'd0, IRWrite}, 32'd1);
        check("lw_pcen", {31'd0, PCEn}, 32'd1);
        check("lw_srcb_f", {30'd0, ALUSrcB}, 32'd1);
        check("lw_iord_f", {31'd0, IorD}, 32'd0);
        next_cycle();
        check("lw_s1", {28'd0, State}, 32'd1);
        check("lw_srcb_d", {30'd0, ALUSrcB}, 32'd3);
        check("lw_alu_d", {29'd0, ALUControl}, 32'd2);
        next_cycle();
        check("lw_s2", {28'd0, State}, 32'd2);
        check("lw_srca", {31'd0, ALUSrcA}, 32'd1);
        check("lw_srcb_a", {30'd0, ALUSrcB}, 32'd2);
        next_cycle();
        check("lw_s3", {28'd0, State}, 32'd3);
        check("lw_memrd", {31'd0, MemRead}, 32'd1);
        check("lw_iord", {31'd0, IorD}, 32'd1);
        next_cycle();
        check("lw_s4", {28'd0, State}, 32'd4);
        check("lw_regwr", {31'd0, RegWrite}, 32'd1);
        check("lw_m2r", {31'd0, MemtoReg}, 32'd1);
        check("lw_regdst", {31'd0, RegDst}, 32'd0);
        check("lw_cnt_before", InstrCount, 32'd0);
        next_cycle();
        check("lw_s0", {28'd0, State}, 32'd0);
        check("lw_cnt", InstrCount, 32'd1);

        // sw with 3 wait cycles in MEMWR: 7 cycles total
        Op = 6'b101011;
        next_cycle();
        check("sw_s1", {28'd0, State}, 32'd1);
        next_cycle();
        check("sw_s2", {28'd0, State}, 32'd2);
        MemReady = 1'b0;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            check("sw_wait_state", {28'd0, State}, 32'd5);
            check("sw_wait_memwr", {31'd0, MemWrite}, 32'd1);
            check("sw_wait_iord", {31'd0, IorD}, 32'd1);
            check("sw_wait_regwr", {31'd0, RegWrite}, 32'd0);
            check("sw_wait_cnt", InstrCount, 32'd1);
            next_cycle();
        end
        MemReady = 1'b1; #1;
        check("sw_last_state", {28'd0, State}, 32'd5);
        check("sw_last_memwr", {31'd0, MemWrite}, 32'd1);
        next_cycle();
        check("sw_s0", {28'd0, State}, 32'd0);
        check("sw_cnt", InstrCount, 32'd2);

        // beq taken
        Op = 6'b000100; Zero = 1'b1;
        next_cycle();
        next_cycle();
        check("beq_s8", {28'd0, State}, 32'd8);
        check("beq_pcen_t", {31'd0, PCEn}, 32'd1);
        check("beq_pcsrc", {30'd0, PCSrc}, 32'd1);
        check("beq_alu", {29'd0, ALUControl}, 32'd6);
        next_cycle();
        check("beq_s0", {28'd0, State}, 32'd0);
        check("beq_cnt", InstrCount, 32'd3);

        // beq not taken
        Zero = 1'b0;
        next_cycle();
        next_cycle();
        check("beqn_s8", {28'd0, State}, 32'd8);
        check("beqn_pcen", {31'd0, PCEn}, 32'd0);
        next_cycle();
        check("beqn_s0", {28'd0, State}, 32'd0);
        check("beqn_cnt", InstrCount, 32'd4);

        // R-type slt
        Op = 6'b000000; Funct = 6'b101010;
        next_cycle();
        next_cycle();
        check("slt_s6", {28'd0, State}, 32'd6);
        check("slt_alu", {29'd0, ALUControl}, 32'd7);
        check("slt_srcb", {30'd0, ALUSrcB}, 32'd0);
        check("slt_illegal", {31'd0, Illegal}, 32'd0);
        next_cycle();
        check("slt_s7", {28'd0, State}, 32'd7);
        check("slt_regwr", {31'd0, RegWrite}, 32'd1);
        check("slt_regdst", {31'd0, RegDst}, 32'd1);
        check("slt_m2r", {31'd0, MemtoReg}, 32'd0);
        next_cycle();
        check("slt_cnt", InstrCount, 32'd5);

        // R-type with unsupported funct
        Funct = 6'b000111;
        next_cycle();
        next_cycle();
        check("badfn_s6", {28'd0, State}, 32'd6);
        check("badfn_illegal", {31'd0, Illegal}, 32'd1);
        check("badfn_alu", {29'd0, ALUControl}, 32'd2);
        check("badfn_regwr", {31'd0, RegWrite}, 32'd0);
        next_cycle();
        check("badfn_s0", {28'd0, State}, 32'd0);
        check("badfn_illegal_off", {31'd0, Illegal}, 32'd0);
        check("badfn_cnt", InstrCount, 32'd5);

        // Unsupported opcode
        Op = 6'b111111;
        next_cycle();
        check("badop_s1", {28'd0, State}, 32'd1);
        check("badop_illegal", {31'd0, Illegal}, 32'd1);
        check("badop_regwr", {31'd0, RegWrite}, 32'd0);
        check("badop_memwr", {31'd0, MemWrite}, 32'd0);
        check("badop_pcen", {31'd0, PCEn}, 32'd0);
        next_cycle();
        check("badop_s0", {28'd0, State}, 32'd0);
        check("badop_cnt", InstrCount, 32'd5);

        // addi
        Op = 6'b001000;
        next_cycle();
        next_cycle();
        check("addi_s9", {28'd0, State}, 32'd9);
        check("addi_srcb", {30'd0, ALUSrcB}, 32'd2);
        next_cycle();
        check("addi_s10", {28'd0, State}, 32'd10);
        check("addi_regwr", {31'd0, RegWrite}, 32'd1);
        check("addi_regdst", {31'd0, RegDst}, 32'd0);
        next_cycle();
        check("addi_cnt", InstrCount, 32'd6);

        // j: 3 cycles
        Op = 6'b000010;
        next_cycle();
        next_cycle();
        check("j_s11", {28'd0, State}, 32'd11);
        check("j_pcsrc", {30'd0, PCSrc}, 32'd2);
        check("j_pcen", {31'd0, PCEn}, 32'd1);
        next_cycle();
        check("j_s0", {28'd0, State}, 32'd0);
        check("j_cnt", InstrCount, 32'd7);

        // Reset during a MEMRD wait
        Op = 6'b100011;
        next_cycle();
        next_cycle();
        MemReady = 1'b0;
        next_cycle();
        check("rw_s3", {28'd0, State}, 32'd3);
        check("rw_memrd", {31'd0, MemRead}, 32'd1);
        RST = 1'b1; #1;
        check("rw_memrd_forced", {31'd0, MemRead}, 32'd0);
        next_cycle();
        MemReady = 1'b1; #1;
        check("rw_state", {28'd0, State}, 32'd0);
        check("rw_cnt", InstrCount, 32'd0);
        check("rw_memread", {31'd0, MemRead}, 32'd0);
        check("rw_irwrite", {31'd0, IRWrite}, 32'd0);
        check("rw_pcen", {31'd0, PCEn}, 32'd0);
        RST = 1'b0; #1;
        check("rw_fetch_resume", {31'd0, MemRead}, 32'd1);
        check("rw_fetch_ir", {31'd0, IRWrite}, 32'd1);
        next_cycle();
        check("rw_s1", {28'd0, State}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
